// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit.
// Holds the state encodings, the opcode and funct field values the FSM
// decodes, the alu_ctrl codes, the alu_op request codes passed to the ALU
// decoder, and the alu_src_b / pc_src mux select codes.
package mc_control_fsm_pkg;

  // Binary state encoding; codes 12..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation requests from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder for the multi-cycle MIPS control unit.
// Turns the FSM's alu_op request into the 3-bit alu_ctrl code. alu_op 00
// forces add, 01 forces sub, 10 decodes the R-type funct field (unknown
// funct values fall back to add). The unused alu_op code 11 also gives add.
// Ports:
//   alu_op   in  2  operation request from the FSM
//   funct    in  6  IR[5:0]
//   alu_ctrl out 3  ALU control code
module alu_decoder
  import mc_control_fsm_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  // Pure lookup; add is the safe default for anything unrecognised.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control unit of the multi-cycle MIPS core.
// Steps each instruction through fetch/decode/execute/memory/writeback
// states and drives the datapath mux selects and write enables.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   op, funct             IR[31:26], IR[5:0]
//   zero                  ALU zero flag (same cycle)
//   pc_en                 PC load = pc_write | (branch & zero)
//   iord                  memory address select (0 PC, 1 ALUOut)
//   mem_write, ir_write   memory / IR write enables
//   reg_dst, mem_to_reg   writeback register / data selects
//   reg_write             register file write enable
//   alu_src_a, alu_src_b  ALU operand selects
//   pc_src                next PC select
//   alu_ctrl              ALU operation code
//   state                 current state, for debug
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int ST_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_ctrl,
  output logic [ST_W-1:0]    state
);

  state_t     r_state;
  state_t     w_next;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_alu_op;

  // State register; reset lands in FETCH regardless of where we were.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state and Moore output decode. alu_op defaults to add, so states
  // that do not use the ALU still present alu_ctrl = add.
  always_comb begin
    w_next      = S_FETCH;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_alu_op    = ALUOP_ADD;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_src      = PCSRC_ALU;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        alu_src_b  = SRCB_FOUR;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while op is decoded.
        alu_src_b = SRCB_IMM_SH;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BEQ;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        w_alu_op  = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are suppressed combinationally during reset so an
  // aborted instruction cannot corrupt architectural state.
  assign pc_en     = ~reset & (w_pc_write | (w_branch & zero));
  assign mem_write = ~reset & w_mem_write;
  assign ir_write  = ~reset & w_ir_write;
  assign reg_write = ~reset & w_reg_write;
  assign state     = r_state;

  alu_decoder u_alu_decoder (
    .alu_op   (w_alu_op),
    .funct    (funct[5:0]),
    .alu_ctrl (alu_ctrl)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for the multi-cycle MIPS control FSM. A reference model describes
// each instruction as its list of visited steps plus the control word each
// step must present; directed steps cover reset, lw, slt, beq taken/not
// taken, reset during a store and an unsupported opcode, followed by a
// randomized instruction stream.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pcEn;
    logic       iord;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       srcA;
    logic [1:0] srcB;
    logic [1:0] pcSrc;
    logic [2:0] alu;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_ctrl   (alu_ctrl),
    .state      (state)
  );

  // 20 ns clock
  always #10 clk = ~clk;

  // Steps visited by each instruction class, starting at fetch.
  function automatic int pathLen(logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  function automatic int stepAt(logic [5:0] o, int i);
    int seq[5];
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5, 0};
      6'b000000: seq = '{0, 1, 6, 7, 0};
      6'b001000: seq = '{0, 1, 9, 10, 0};
      6'b000100: seq = '{0, 1, 8, 0, 0};
      6'b000010: seq = '{0, 1, 11, 0, 0};
      default:   seq = '{0, 1, 0, 0, 0};
    endcase
    return seq[i];
  endfunction

  function automatic logic [2:0] functAlu(logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Control word expected in a given step.
  function automatic ctl_t ctlFor(int s, logic [5:0] f, logic z);
    ctl_t c;
    c = '0;
    c.alu = 3'b010;
    case (s)
      0:  begin c.irWrite = 1'b1; c.srcB = 2'b01; c.pcEn = 1'b1; end
      1:  c.srcB = 2'b11;
      2:  begin c.srcA = 1'b1; c.srcB = 2'b10; end
      3:  c.iord = 1'b1;
      4:  begin c.memToReg = 1'b1; c.regWrite = 1'b1; end
      5:  begin c.iord = 1'b1; c.memWrite = 1'b1; end
      6:  begin c.srcA = 1'b1; c.alu = functAlu(f); end
      7:  begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      8:  begin c.srcA = 1'b1; c.alu = 3'b110; c.pcSrc = 2'b01; c.pcEn = z; end
      9:  begin c.srcA = 1'b1; c.srcB = 2'b10; end
      10: c.regWrite = 1'b1;
      11: begin c.pcSrc = 2'b10; c.pcEn = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t noWrites(ctl_t c);
    ctl_t r;
    r = c;
    r.pcEn = 1'b0;
    r.memWrite = 1'b0;
    r.irWrite = 1'b0;
    r.regWrite = 1'b0;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input int expState, input ctl_t exp);
    ctl_t obs;
    obs = '{pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, pc_src, alu_ctrl};
    checks++;
    assert (state === 4'(expState))
      else begin
        errors++;
        $error("[TB] FAIL %s state: observed=%0d expected=%0d", tag, state, expState);
      end
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s ctl: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Runs one whole instruction; entered and left #1 after a rising edge.
  task automatic applyStimulus(input string tag, input logic [5:0] o, input logic [5:0] f,
                               input int zMode);
    int s;
    op = o;
    funct = f;
    for (int i = 0; i < pathLen(o); i++) begin
      s = stepAt(o, i);
      zero = (zMode == 2) ? 1'($urandom) : 1'(zMode);
      @(negedge clk);
      checkOutput(tag, s, ctlFor(s, f, zero));
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] supported[6];
  logic [5:0] functs[5];
  logic [5:0] rop, rfn;

  initial begin
    supported = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Reset held for two edges: fetch state with every enable blocked.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset", 0, noWrites(ctlFor(0, 6'd0, 1'b0)));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Load word, then slt, beq taken and not taken, jump, addi
    applyStimulus("lw", 6'b100011, 6'd0, 2);
    applyStimulus("slt", 6'b000000, 6'b101010, 2);
    applyStimulus("beq_taken", 6'b000100, 6'd0, 1);
    applyStimulus("beq_not", 6'b000100, 6'd0, 0);
    applyStimulus("j", 6'b000010, 6'd0, 2);
    applyStimulus("addi", 6'b001000, 6'd0, 2);

    // Store aborted by reset in the memory-write step
    op = 6'b101011;
    funct = 6'd0;
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("sw_pre", stepAt(6'b101011, i), ctlFor(stepAt(6'b101011, i), 6'd0, 1'b0));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("sw_reset", 5, noWrites(ctlFor(5, 6'd0, 1'b0)));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Unsupported opcode runs as a two-step nop
    applyStimulus("nop", 6'b111111, 6'd0, 2);
    applyStimulus("after_nop", 6'b000000, 6'b100010, 2);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 6) == 6) begin
        do rop = 6'($urandom_range(0, 63));
        while (rop inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010});
      end else begin
        rop = supported[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 1) == 1) rfn = functs[$urandom_range(0, 4)];
      else                           rfn = 6'($urandom_range(0, 63));
      applyStimulus("rand", rop, rfn, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
